// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
// Holds the FSM state encoding, default widths and the id-width helper.
package cordic_ctrl_pkg;

    localparam int DATA_W      = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Requester-id width, never below one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr wins,
// with the search wrapping from N-1 back to 0.
module rr_arbiter
    import cordic_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    logic found;
    logic take;
    int   idx;

    // Walk the requests starting at ptr and keep the first hit.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        found      = 1'b0;
        take       = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx             = (int'(ptr) + k) % N;
            take            = req[idx] & ~found;
            gnt_onehot[idx] = take;
            gnt_id          = take ? ID_W'(idx) : gnt_id;
            found           = found | take;
        end
    end

    assign any = |req;

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one start/done CORDIC cosine accelerator between N_REQ requesters:
// round-robin grant, start sequencing, stale-done masking and a WAIT watchdog.
module cordic_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = cordic_ctrl_pkg::TIMEOUT_DEF,
    parameter int DATA_W  = cordic_ctrl_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_x_ft,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_W-1:0]       rsp_y_ft,
    output logic                    busy,
    output logic                    acc_start,
    output logic [DATA_W-1:0]       acc_x_ft,
    input  logic                    acc_done,
    input  logic [DATA_W-1:0]       acc_y_ft
);

    import cordic_ctrl_pkg::*;

    localparam int ID_W  = id_w(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONEHOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W-1:0]   acc_x_q, acc_x_d;
    logic [DATA_W-1:0]   rsp_y_q, rsp_y_d;
    logic                rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic                acc_start_q, acc_start_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    gnt_onehot_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic                gnt_any_s;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot_s),
        .gnt_id     (gnt_id_s),
        .any        (gnt_any_s)
    );

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        acc_x_d     = acc_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        acc_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any_s) begin
                    id_d      = gnt_id_s;
                    acc_x_d   = req_x_ft[int'(gnt_id_s)*DATA_W +: DATA_W];
                    req_ack_d = gnt_onehot_s;
                    state_d   = ISSUE;
                end else begin
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                acc_start_d = 1'b1;
                timer_d     = '0;
                state_d     = SETTLE;
            end
            // The accelerator only drops its stale done once it has seen start.
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (acc_done) begin
                    rsp_y_d     = acc_y_ft;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = ONEHOT0 << id_q;
                    state_d     = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_y_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = ONEHOT0 << id_q;
                    state_d     = RESP;
                end else begin
                    timer_d     = timer_q + TMR_W'(1);
                end
            end
            RESP: begin
                rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset wins over clk_en, clk_en low freezes all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            acc_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            acc_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            acc_x_q     <= acc_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            acc_start_q <= acc_start_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_y_ft  = rsp_y_q;
    assign busy      = busy_q;
    assign acc_start = acc_start_q;
    assign acc_x_ft  = acc_x_q;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Scoreboard bench for cordic_share_ctrl with a behavioural accelerator:
// done drops on start and rises 6 cycles later carrying y = x + 1.
module tb_cordic_share_ctrl;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_x_ft;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      rsp_valid;
    logic              rsp_err;
    logic [DW-1:0]     rsp_y_ft;
    logic              busy;
    logic              acc_start;
    logic [DW-1:0]     acc_x_ft;

    logic              acc_done_m = 1'b1;
    logic [DW-1:0]     acc_y_m    = 32'h0000_0000;
    logic [DW-1:0]     pend_y     = 32'h0000_0000;
    int                acc_cnt    = 0;
    logic              acc_hang;

    typedef struct {
        int          id;
        logic [31:0] y;
        logic        err;
        int          t;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    cordic_share_ctrl #(.N_REQ(N), .TIMEOUT(TO), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .req       (req),
        .req_x_ft  (req_x_ft),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_y_ft  (rsp_y_ft),
        .busy      (busy),
        .acc_start (acc_start),
        .acc_x_ft  (acc_x_ft),
        .acc_done  (acc_done_m),
        .acc_y_ft  (acc_y_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator model, advancing on the same enable as the controller.
    always @(posedge clk) begin
        if (clk_en) begin
            if (acc_start) begin
                acc_done_m <= 1'b0;
                acc_cnt    <= acc_hang ? 0 : 6;
                pend_y     <= acc_x_ft + 32'd1;
            end else if (acc_cnt != 0) begin
                acc_cnt <= acc_cnt - 1;
                if (acc_cnt == 1) begin
                    acc_done_m <= 1'b1;
                    acc_y_m    <= pend_y;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response scoreboard: each enabled rsp_valid pulse pops one expectation.
    always @(negedge clk) begin
        if (reset && clk_en) begin
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    check_val("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check_val("rsp_onehot", 64'(rsp_valid), 64'd1 << e.id);
                    check_val("rsp_y", 64'(rsp_y_ft), 64'(e.y));
                    check_val("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.t >= 0) check_val("rsp_latency", 64'(cyc), 64'(e.t));
                end
            end
            if (req_ack != '0) check_val("ack_onehot", 64'($onehot(req_ack)), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req = req & ~req_ack;
    endtask

    task automatic post(input int id, input logic [31:0] x, input logic [31:0] y,
                        input logic err, input int t);
        exp_t p;
        req_x_ft[id*DW +: DW] = x;
        req[id]               = 1'b1;
        p.id = id; p.y = y; p.err = err; p.t = t;
        sbq.push_back(p);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            check_val("drain_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_ack"},   64'(req_ack),   64'd0);
        check_val({tag, "_rsp"},   64'(rsp_valid), 64'd0);
        check_val({tag, "_busy"},  64'(busy),      64'd0);
        check_val({tag, "_start"}, 64'(acc_start), 64'd0);
        check_val({tag, "_x"},     64'(acc_x_ft),  64'd0);
        check_val({tag, "_y"},     64'(rsp_y_ft),  64'd0);
        check_val({tag, "_err"},   64'(rsp_err),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        reset    = 1'b0;
        clk_en   = 1'b1;
        req      = '0;
        req_x_ft = '0;
        acc_hang = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        reset = 1'b1;
        tick();

        // Single request: ack, start, then result 10 cycles after the request.
        post(0, 32'h3F80_0000, 32'h3F80_0001, 1'b0, cyc + 10);
        tick();
        check_val("t1_ack", 64'(req_ack), 64'h1);
        tick();
        check_val("t1_start", 64'(acc_start), 64'h1);
        check_val("t1_acc_x", 64'(acc_x_ft), 64'h3F80_0000);
        drain(40);

        // Contention from reset exit, requester 0 comes back after its response.
        reset = 1'b0;
        for (int i = 0; i < N; i++) post(i, 32'h4000_0000 + 32'(i * 16), 32'h4000_0001 + 32'(i * 16), 1'b0, -1);
        tick();
        reset = 1'b1;
        n = 0;
        while (sbq.size() > 3 && n < 40) begin
            tick();
            n++;
        end
        check_val("t2_first_served", 64'(sbq.size()), 64'd3);
        post(0, 32'h4100_0000, 32'h4100_0001, 1'b0, -1);
        drain(120);

        // Pointer wrap: id 2 alone leaves the pointer at 3, then 3 beats 0.
        post(2, 32'h4200_0000, 32'h4200_0001, 1'b0, -1);
        drain(40);
        post(3, 32'h4300_0000, 32'h4300_0001, 1'b0, -1);
        post(0, 32'h4400_0000, 32'h4400_0001, 1'b0, -1);
        drain(60);

        // Watchdog: no done after start gives an error response; pointer still moves.
        acc_hang = 1'b1;
        post(1, 32'h4500_0000, 32'h0000_0000, 1'b1, cyc + TO + 3);
        drain(100);
        acc_hang = 1'b0;
        post(0, 32'h4600_0000, 32'h4600_0001, 1'b0, -1);
        post(1, 32'h4700_0000, 32'h4700_0001, 1'b0, -1);
        drain(60);

        // Stale done from the previous operation must not be taken as completion.
        post(2, 32'h4800_0000, 32'h4800_0001, 1'b0, cyc + 10);
        drain(40);

        // Enable gating of a pulse and of WAIT, then reset with an operation in flight.
        req_x_ft[3*DW +: DW] = 32'h4900_0000;
        req[3] = 1'b1;
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t6_ack_stretch", 64'(req_ack), 64'h8);
        end
        clk_en = 1'b1;
        tick();
        check_val("t6_ack_done", 64'(req_ack), 64'h0);
        check_val("t6_start", 64'(acc_start), 64'h1);
        tick();
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t6_hold_busy", 64'(busy), 64'h1);
            check_val("t6_hold_x", 64'(acc_x_ft), 64'h4900_0000);
            check_val("t6_hold_rsp", 64'(rsp_valid), 64'h0);
            check_val("t6_hold_start", 64'(acc_start), 64'h0);
        end
        clk_en = 1'b1;
        reset  = 1'b0;
        tick();
        check_zero_outputs("t6_reset");
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        post(1, 32'h4A00_0000, 32'h4A00_0001, 1'b0, cyc + 10);
        post(3, 32'h4B00_0000, 32'h4B00_0001, 1'b0, -1);
        drain(60);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
